// File: rtl/ram_init_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ram_init_master: writes addr^SEED to 0..max_addr, reads back, compares |
// | Optional: RAM_INIT_STATS_EN adds err_count / first_err_addr outputs     |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module ram_init_master #(
  parameter int         AW   = 8,
  parameter int         DW   = 8,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] max_addr,
  output logic          req_valid,
  output logic          req_write,
  output logic [AW-1:0] req_addr,
  output logic [DW-1:0] req_wdata,
  input  logic          req_ready,
  input  logic          rsp_valid,
  input  logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic          done,
  output logic          pass
`ifdef RAM_INIT_STATS_EN
  ,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_err_addr
`endif
);

  localparam logic [DW-1:0] c_seed = DW'(SEED);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD       = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_FIN      = 3'd4
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_max;

  logic          w_hs;
  logic          w_last;
  logic [AW-1:0] w_next;
  logic [DW-1:0] w_expect;

  assign w_hs     = req_valid && req_ready;
  assign w_last   = (r_addr == r_max);
  assign w_next   = r_addr + 1'b1;
  assign w_expect = DW'(r_addr) ^ c_seed;
  assign req_addr = r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_max     <= '0;
      req_valid <= 1'b0;
      req_write <= 1'b0;
      req_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
`ifdef RAM_INIT_STATS_EN
      err_count      <= '0;
      first_err_addr <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr    <= '0;
            r_max     <= max_addr;
            busy      <= 1'b1;
            pass      <= 1'b1;
            req_valid <= 1'b1;
            req_write <= 1'b1;
            req_wdata <= c_seed;
`ifdef RAM_INIT_STATS_EN
            err_count      <= '0;
            first_err_addr <= '0;
`endif
            r_state   <= S_WR;
          end
        end
        S_WR: begin
          if (w_hs) begin
            if (w_last) begin
              r_addr    <= '0;
              req_write <= 1'b0;
              req_wdata <= '0;
              r_state   <= S_RD;
            end else begin
              r_addr    <= w_next;
              req_wdata <= DW'(w_next) ^ c_seed;
            end
          end
        end
        S_RD: begin
          // Responses coinciding with the handshake are not accepted here.
          if (w_hs) begin
            req_valid <= 1'b0;
            r_state   <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_valid) begin
            if (rsp_rdata != w_expect) begin
              pass <= 1'b0;
`ifdef RAM_INIT_STATS_EN
              if (err_count != '1) err_count <= err_count + 1'b1;
              if (err_count == '0) first_err_addr <= r_addr;
`endif
            end
            if (w_last) begin
              done    <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_addr    <= w_next;
              req_valid <= 1'b1;
              r_state   <= S_RD;
            end
          end
        end
        S_FIN: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_init_master.sv
`default_nettype none
// Directed, table-driven bench for ram_init_master with a behavioural RAM that
// answers reads two edges after the handshake and can corrupt one address.
module tb_ram_init_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] max_addr;
  logic       req_valid, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       req_ready = 1'b1;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy, done, pass;
`ifdef RAM_INIT_STATS_EN
  logic [8:0] err_count;
  logic [7:0] first_err_addr;
`endif

  ram_init_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_addr(max_addr),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .done(done), .pass(pass)
`ifdef RAM_INIT_STATS_EN
    , .err_count(err_count), .first_err_addr(first_err_addr)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- RAM model and protocol monitors ----------------
  logic       stall_en = 1'b0;
  logic       corrupt_en = 1'b0;
  logic [7:0] corrupt_addr = 8'h00;
  logic [7:0] cur_max = 8'h00;

  logic [7:0]  mem [256];
  logic        p1_v;
  logic [7:0]  p1_a;
  logic [7:0]  exp_wa, exp_ra;
  logic        pend;
  logic [17:0] pend_f;
  int wr_count = 0, rd_count = 0;
  int bad_wr = 0, bad_rd = 0, bad_range = 0, bad_stable = 0;

  always @(negedge clk) req_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v      <= 1'b0;
      p1_a      <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      pend      <= 1'b0;
      pend_f    <= '0;
      exp_wa    <= 8'h00;
      exp_ra    <= 8'h00;
    end else begin
      rsp_valid <= p1_v;
      rsp_rdata <= (corrupt_en && p1_a == corrupt_addr) ? 8'h00 : mem[p1_a];
      p1_v      <= 1'b0;
      pend      <= req_valid && !req_ready;
      pend_f    <= {req_valid, req_write, req_addr, req_wdata};
      if (pend && pend_f != {req_valid, req_write, req_addr, req_wdata})
        bad_stable <= bad_stable + 1;
      if (req_valid && req_addr > cur_max) bad_range <= bad_range + 1;
      if (!busy) begin
        exp_wa <= 8'h00;
        exp_ra <= 8'h00;
      end else if (req_valid && req_ready) begin
        if (req_write) begin
          mem[req_addr] <= req_wdata;
          wr_count      <= wr_count + 1;
          exp_wa        <= exp_wa + 8'h01;
          if (req_addr != exp_wa || req_wdata != (req_addr ^ 8'hA5)) bad_wr <= bad_wr + 1;
        end else begin
          p1_v     <= 1'b1;
          p1_a     <= req_addr;
          rd_count <= rd_count + 1;
          exp_ra   <= exp_ra + 8'h01;
          if (req_addr != exp_ra || req_wdata != 8'h00) bad_rd <= bad_rd + 1;
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] max;
    bit         corrupt;
    logic [7:0] caddr;
    bit         stall;
    int         poke;       // cycle at which start is re-pulsed and max_addr changed (0 = none)
    bit         exp_pass;
    int         exp_busy;   // 0 = latency not checked (stalled runs)
    int         exp_err;
    logic [7:0] exp_first;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input string tag);
    int b_wr = wr_count, b_rd = rd_count;
    int b_bw = bad_wr, b_br = bad_rd, b_rg = bad_range, b_st = bad_stable;
    int busy_c = 0, done_c = 0, post = 0;
    bit seen = 0;
    corrupt_en   = v.corrupt;
    corrupt_addr = v.caddr;
    stall_en     = v.stall;
    cur_max      = v.max;
    max_addr     = v.max;
    start        = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (v.poke != 0 && c == v.poke) begin start = 1'b1; max_addr = 8'h01; end
      if (v.poke != 0 && c == v.poke + 1) start = 1'b0;
      if (busy) busy_c++;
      if (done) begin done_c++; seen = 1; end
      if (seen) post++;
      if (post >= 3) break;
    end
    stall_en = 1'b0;
    chk({tag, " done_pulses"}, done_c, 1);
    chk({tag, " pass"}, {31'd0, pass}, {31'd0, v.exp_pass});
    chk({tag, " busy_after"}, {31'd0, busy}, 0);
    chk({tag, " writes"}, wr_count - b_wr, v.max + 1);
    chk({tag, " reads"}, rd_count - b_rd, v.max + 1);
    chk({tag, " bad_write_addr_data"}, bad_wr - b_bw, 0);
    chk({tag, " bad_read_addr"}, bad_rd - b_br, 0);
    chk({tag, " addr_over_max"}, bad_range - b_rg, 0);
    chk({tag, " unstable_while_stalled"}, bad_stable - b_st, 0);
    if (v.exp_busy != 0) chk({tag, " busy_cycles"}, busy_c, v.exp_busy);
`ifdef RAM_INIT_STATS_EN
    chk({tag, " err_count"}, {23'd0, err_count}, v.exp_err);
    chk({tag, " first_err_addr"}, {24'd0, first_err_addr}, {24'd0, v.exp_first});
`endif
  endtask

  initial begin
    vec_t tail;
    rst_n    = 1'b0;
    start    = 1'b0;
    max_addr = 8'h00;
    // busy cycles without stalls: (max+1) writes + 3*(max+1) read cycles + FIN
    vecs[0] = '{8'h03, 1'b0, 8'h00, 1'b0, 0,  1'b1, 17,   0, 8'h00};
    vecs[1] = '{8'h00, 1'b0, 8'h00, 1'b0, 0,  1'b1, 5,    0, 8'h00};
    vecs[2] = '{8'h05, 1'b1, 8'h02, 1'b0, 0,  1'b0, 25,   1, 8'h02};
    vecs[3] = '{8'h07, 1'b0, 8'h00, 1'b1, 0,  1'b1, 0,    0, 8'h00};
    vecs[4] = '{8'h05, 1'b0, 8'h00, 1'b0, 10, 1'b1, 25,   0, 8'h00};
    vecs[5] = '{8'hFF, 1'b0, 8'h00, 1'b0, 0,  1'b1, 1025, 0, 8'h00};
    vecs[6] = '{8'h04, 1'b1, 8'h04, 1'b1, 0,  1'b0, 0,    1, 8'h04};
    vecs[7] = '{8'h00, 1'b1, 8'h00, 1'b0, 0,  1'b0, 5,    1, 8'h00};
    vecs[8] = '{8'h01, 1'b0, 8'h00, 1'b0, 0,  1'b1, 9,    0, 8'h00};

    repeat (3) @(negedge clk);
    chk("reset req_valid", {31'd0, req_valid}, 0);
    chk("reset req_write", {31'd0, req_write}, 0);
    chk("reset req_addr", {24'd0, req_addr}, 0);
    chk("reset req_wdata", {24'd0, req_wdata}, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset pass", {31'd0, pass}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Asynchronous reset in the middle of the write phase.
    max_addr = 8'hC8;
    cur_max  = 8'hC8;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrun busy_before_reset", {31'd0, busy}, 1);
    chk("midrun writing_before_reset", {31'd0, req_write}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun req_valid", {31'd0, req_valid}, 0);
    chk("midrun req_write", {31'd0, req_write}, 0);
    chk("midrun req_addr", {24'd0, req_addr}, 0);
    chk("midrun req_wdata", {24'd0, req_wdata}, 0);
    chk("midrun busy", {31'd0, busy}, 0);
    chk("midrun pass", {31'd0, pass}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tail = '{8'h01, 1'b0, 8'h00, 1'b0, 0, 1'b1, 9, 0, 8'h00};
    run_vec(tail, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
